serial_frame_tx: RTL and testbench
==================================

Name: serial_frame_tx

Overview:
- Parallel-to-serial frame transmitter, UART-style: LSB-first data, one start bit, one stop bit.
- Built as the transmit end of the serial link; pairs with the team's serial frame receiver.
- Structure: explicit registered state plus separate next-state logic, with registered outputs only.
- Accepts a word over a valid/ready handshake and drives a single idle-high serial line.

Parameters:
- DATA_W, 8, number of data bits per frame (legal range 5..9).
- CLKS_PER_BIT, 16, clk cycles per serial bit period (minimum 2).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_data  input  DATA_W  word to send; sampled only on handshake.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block can accept a word this cycle.
- tx  output  1  serial line; idle level is 1.
- busy  output  1  frame in progress.

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE, tx=1, tx_ready=1, busy=0, bit counter=0, baud counter=0, shift register=0.
- Handshake: a word is accepted on the rising edge where tx_valid=1 and tx_ready=1.
  - tx_data is captured into the shift register on that edge.
  - tx_ready is 0 from the next cycle until the frame completes.
  - tx_valid while tx_ready=0 is ignored; nothing is queued.
- Latency: tx falls to 0 (start bit) on the first cycle after acceptance.
- Bit timing: each bit is held for exactly CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at bit end.
- States:
  - IDLE: tx=1, tx_ready=1, busy=0. Handshake -> START.
  - START: tx=0 for one bit period -> DATA.
  - DATA: tx = shift register bit 0. At each bit end, shift right and increment the bit counter. After DATA_W bits -> PARITY if the option is compiled in, else -> STOP.
  - PARITY: see Optional Feature; one bit period -> STOP.
  - STOP: tx=1 for one bit period -> IDLE.
- Frame length: (DATA_W+2)*CLKS_PER_BIT cycles, or (DATA_W+3)*CLKS_PER_BIT with parity. Acceptance cycle is excluded.
- Back-to-back frames:
  - tx_ready rises on the cycle the STOP bit ends (state returns to IDLE).
  - A handshake on that cycle starts the next start bit on the following cycle.
  - So at most one idle-high cycle appears between frames.
- Registered outputs: tx, tx_ready and busy are all flops, so no combinational path runs from tx_valid to tx_ready.
- Reset mid-frame: tx returns to 1 immediately (asynchronous) and all state clears; the partial frame is abandoned.
- tx_data changing after acceptance has no effect on the frame in progress.
- Counter widths: ceil(log2(CLKS_PER_BIT)) for the baud counter, ceil(log2(DATA_W+1)) for the bit counter. No overflow is permitted.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined:
  - The PARITY state is present.
  - The parity bit is even parity: XOR of the DATA_W bits, captured at handshake.
  - The frame carries DATA_W+3 bits.
- Undefined:
  - The PARITY state and its logic are absent; DATA goes directly to STOP.
  - The frame carries DATA_W+2 bits.

Test Plan:
- Reset, then hold 50 cycles -> tx=1, tx_ready=1, busy=0 throughout.
- DATA_W=8, CLKS_PER_BIT=16, send 8'hA5 (macro undefined) -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 16 cycles; tx_ready=0 for 160 cycles.
- Same frame with SERIAL_TX_PARITY_EN, data 8'h07 -> parity bit 1 after data bits 1,1,1,0,0,0,0,0; frame 176 cycles.
- Hold tx_valid=1 continuously with 8'h55 then 8'hFF -> second start bit begins one cycle after the first stop bit ends; 8'hFF is ignored while busy.
- Assert rst_n=0 during DATA bit 3 -> tx=1 in the same cycle; after release, idle state, and a new handshake sends a complete clean frame.
- CLKS_PER_BIT=2, DATA_W=5, send 5'h11 -> 14-cycle frame, bit boundaries every 2 cycles, no counter wrap errors.

Source files
------------

// File: rtl/serial_frame_tx.sv
// UART-style frame transmitter: start bit, DATA_W data bits LSB first, optional
// even parity bit (SERIAL_TX_PARITY_EN), stop bit. The serial line idles high.
module serial_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_W + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  logic parity_bit;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;
`endif

  state_t              state;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [DATA_W-1:0]   shreg;
  logic                bit_end;
  logic                accept;

  always_comb begin
    bit_end = (baud_cnt == BAUD_LAST);
    accept  = tx_valid && tx_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      shreg    <= '0;
`ifdef SERIAL_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (accept) begin
            shreg    <= tx_data;
`ifdef SERIAL_TX_PARITY_EN
            parity_bit <= even_parity(tx_data);
`endif
            state    <= S_START;
            tx       <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end

        S_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= S_DATA;
            tx       <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            shreg    <= shreg >> 1;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
`ifdef SERIAL_TX_PARITY_EN
              state   <= S_PARITY;
              tx      <= parity_bit;
`else
              state   <= S_STOP;
              tx      <= 1'b1;
`endif
            end else begin
              // next data bit is the one about to shift into position 0
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

`ifdef SERIAL_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= S_STOP;
            tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (bit_end) begin
            // ready rises as the stop bit ends so a new word can start next cycle
            baud_cnt <= '0;
            state    <= S_IDLE;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state    <= S_IDLE;
          tx       <= 1'b1;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: an 8-bit/16-clk instance and a 5-bit/2-clk instance,
// checked cycle by cycle against a queue of expected line bits.
module tb_serial_frame_tx;

`ifdef SERIAL_TX_PARITY_EN
  localparam int EXTRA = 3;
`else
  localparam int EXTRA = 2;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data_a;
  logic       tx_valid_a, tx_ready_a, tx_a, busy_a;
  logic [4:0] tx_data_b;
  logic       tx_valid_b, tx_ready_b, tx_b, busy_b;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  logic exp_q[$];

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a), .tx(tx_a), .busy(busy_a)
  );

  serial_frame_tx #(.DATA_W(5), .CLKS_PER_BIT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .tx(tx_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_tx(input int sel);
    return (sel == 0) ? tx_a : tx_b;
  endfunction

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? tx_ready_a : tx_ready_b;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy_a : busy_b;
  endfunction

  // expected line bits for one frame: start, data LSB first, [parity], stop
  function automatic void push_frame(input logic [7:0] d, input int dw);
    exp_q.push_back(1'b0);
    for (int i = 0; i < dw; i++) exp_q.push_back(d[i]);
`ifdef SERIAL_TX_PARITY_EN
    exp_q.push_back(^(d & 8'((1 << dw) - 1)));
`endif
    exp_q.push_back(1'b1);
  endfunction

  // called at a negedge; returns at the negedge of the first frame cycle
  task automatic handshake(input int sel, input logic [7:0] d, input int dw);
    chk($sformatf("ready_before_hs%0d", sel), get_ready(sel), 1'b1);
    if (sel == 0) begin
      tx_data_a  = d;
      tx_valid_a = 1'b1;
    end else begin
      tx_data_b  = d[4:0];
      tx_valid_b = 1'b1;
    end
    push_frame(d, dw);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_frame(input int sel, input int cpb, input int nbits, input string tag);
    logic expb;
    expb = 1'b1;
    for (int k = 0; k < nbits * cpb; k++) begin
      if (k % cpb == 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $error("FAIL %s: scoreboard empty at cycle %0d", tag, k);
        end else begin
          expb = exp_q.pop_front();
        end
      end
      chk($sformatf("%s_tx_c%0d", tag, k), get_tx(sel), expb);
      chk($sformatf("%s_ready_c%0d", tag, k), get_ready(sel), 1'b0);
      chk($sformatf("%s_busy_c%0d", tag, k), get_busy(sel), 1'b1);
      @(negedge clk);
    end
    chk($sformatf("%s_end_ready", tag), get_ready(sel), 1'b1);
    chk($sformatf("%s_end_busy", tag), get_busy(sel), 1'b0);
    chk($sformatf("%s_end_tx", tag), get_tx(sel), 1'b1);
    chk($sformatf("%s_q_empty", tag), exp_q.size(), 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    tx_valid_a = 1'b0;
    tx_data_a  = '0;
    tx_valid_b = 1'b0;
    tx_data_b  = '0;

    // reset state and idle hold
    @(negedge clk);
    chk("rst_tx_a", tx_a, 1'b1);
    chk("rst_ready_a", tx_ready_a, 1'b1);
    chk("rst_busy_a", busy_a, 1'b0);
    chk("rst_tx_b", tx_b, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_tx_a", tx_a, 1'b1);
      chk("idle_ready_a", tx_ready_a, 1'b1);
      chk("idle_busy_a", busy_a, 1'b0);
      chk("idle_tx_b", tx_b, 1'b1);
      chk("idle_ready_b", tx_ready_b, 1'b1);
      chk("idle_busy_b", busy_b, 1'b0);
    end

    // single frame 8'hA5
    handshake(0, 8'hA5, 8);
    tx_valid_a = 1'b0;
    check_frame(0, 16, 8 + EXTRA, "a5");
    @(negedge clk);

    // single frame 8'h07 (odd ones count -> parity 1 when enabled)
    handshake(0, 8'h07, 8);
    tx_valid_a = 1'b0;
    tx_data_a  = 8'h00;
    check_frame(0, 16, 8 + EXTRA, "h07");
    @(negedge clk);

    // back-to-back: valid held high, data switches to FF while busy
    handshake(0, 8'h55, 8);
    tx_data_a = 8'hFF;
    check_frame(0, 16, 8 + EXTRA, "b2b_55");
    handshake(0, 8'hFF, 8);
    tx_valid_a = 1'b0;
    check_frame(0, 16, 8 + EXTRA, "b2b_ff");
    @(negedge clk);

    // reset during data bit 3 (A5 bit3 = 0, so the line is low beforehand)
    handshake(0, 8'hA5, 8);
    tx_valid_a = 1'b0;
    repeat (70) @(negedge clk);
    chk("mid_tx_before_rst", tx_a, 1'b0);
    chk("mid_busy_before_rst", busy_a, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", tx_a, 1'b1);
    chk("mid_rst_ready", tx_ready_a, 1'b1);
    chk("mid_rst_busy", busy_a, 1'b0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_tx", tx_a, 1'b1);
      chk("post_rst_ready", tx_ready_a, 1'b1);
      chk("post_rst_busy", busy_a, 1'b0);
    end
    handshake(0, 8'hC3, 8);
    tx_valid_a = 1'b0;
    check_frame(0, 16, 8 + EXTRA, "post_rst_c3");
    @(negedge clk);

    // minimum bit period, narrow word
    handshake(1, 8'h11, 5);
    tx_valid_b = 1'b0;
    check_frame(1, 2, 5 + EXTRA, "b_11");
    @(negedge clk);

    handshake(1, 8'h0E, 5);
    tx_valid_b = 1'b0;
    check_frame(1, 2, 5 + EXTRA, "b_0e");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
